// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  // Load sequencing: idle, instruction copy, data copy, finished.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  // Instruction-stream terminator.
  localparam logic [31:0] HALT_WORD = 32'hffff_ffff;

  // Write-port memory select encodings.
  localparam logic MEM_INST = 1'b0;
  localparam logic MEM_DATA = 1'b1;

  // Index width needed to address an image of the given depth (at least 1 bit).
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Valid/ready write port from the loader into the core's memories.
interface prog_loader_if #(
  parameter int ADDR_W = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (output wr_valid, wr_sel, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_valid, wr_sel, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: copies the instruction image (up to the first halt word) and
// optionally the data image into core memory, holding the core in reset until
// the copy completes.
module prog_loader
  import loader_pkg::*;
#(
  parameter int          INST_DEPTH = 44,
  parameter int          DATA_DEPTH = 500,
  parameter int          ADDR_W     = 16,
  parameter int          LOAD_DATA  = 1,
  parameter logic [31:0] HALT_WORD  = loader_pkg::HALT_WORD
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [31:0]       img_inst [INST_DEPTH],
  input  logic [31:0]       img_data [DATA_DEPTH],
  prog_loader_if.master     wr,
  output logic              busy,
  output logic              done,
  output logic              core_rstn,
  output logic [ADDR_W-1:0] inst_count
);

  localparam int IIW = idx_w(INST_DEPTH);
  localparam int DIW = idx_w(DATA_DEPTH);
  localparam logic [ADDR_W-1:0] INST_LAST = ADDR_W'(INST_DEPTH - 1);
  localparam logic [ADDR_W-1:0] DATA_LAST = ADDR_W'(DATA_DEPTH - 1);
  localparam logic [ADDR_W-1:0] INST_MAX  = ADDR_W'(INST_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic              wr_valid_q, wr_valid_d;
  logic              wr_sel_q, wr_sel_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              core_rstn_q, core_rstn_d;
  logic [ADDR_W-1:0] inst_count_q, inst_count_d;
  logic [31:0]       word;
  logic              accept;

  assign accept = wr_valid_q & wr.wr_ready;

  // Current beat's word, picked straight from the selected image; zero when idle.
  always_comb begin
    word = '0;
    if (wr_valid_q) begin
      if (wr_sel_q == MEM_DATA) word = img_data[wr_addr_q[DIW-1:0]];
      else                      word = img_inst[wr_addr_q[IIW-1:0]];
    end
  end

  // Next-state and registered-output logic for the load sequencer.
  always_comb begin
    state_d      = state_q;
    wr_valid_d   = wr_valid_q;
    wr_sel_d     = wr_sel_q;
    wr_addr_d    = wr_addr_q;
    busy_d       = busy_q;
    done_d       = done_q;
    core_rstn_d  = core_rstn_q;
    inst_count_d = inst_count_q;
    unique case (state_q)
      IDLE, DONE: begin
        // A restart from DONE re-asserts core reset on the same edge.
        if (start) begin
          state_d      = INST;
          wr_valid_d   = 1'b1;
          wr_sel_d     = MEM_INST;
          wr_addr_d    = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          core_rstn_d  = 1'b0;
          inst_count_d = '0;
        end
      end
      INST: begin
        if (accept) begin
          if (inst_count_q != INST_MAX) inst_count_d = inst_count_q + ADDR_ONE;
          if (word == HALT_WORD || wr_addr_q == INST_LAST) begin
            if (LOAD_DATA != 0) begin
              // Move straight to data beat 0 so there is no bubble.
              state_d   = DATA;
              wr_sel_d  = MEM_DATA;
              wr_addr_d = '0;
            end else begin
              state_d     = DONE;
              wr_valid_d  = 1'b0;
              wr_sel_d    = MEM_INST;
              wr_addr_d   = '0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              core_rstn_d = 1'b1;
            end
          end else begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
          end
        end
      end
      DATA: begin
        if (accept) begin
          if (wr_addr_q == DATA_LAST) begin
            state_d     = DONE;
            wr_valid_d  = 1'b0;
            wr_sel_d    = MEM_INST;
            wr_addr_d   = '0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            core_rstn_d = 1'b1;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      wr_valid_q   <= 1'b0;
      wr_sel_q     <= MEM_INST;
      wr_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      core_rstn_q  <= 1'b0;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_valid_q   <= wr_valid_d;
      wr_sel_q     <= wr_sel_d;
      wr_addr_q    <= wr_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      core_rstn_q  <= core_rstn_d;
      inst_count_q <= inst_count_d;
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_sel   = wr_sel_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = word;
  assign busy        = busy_q;
  assign done        = done_q;
  assign core_rstn   = core_rstn_q;
  assign inst_count  = inst_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader. Two instances: one without
// the data phase (dut 0) and one with an 8-word data image (dut 1).
`timescale 1ns/1ps
module tb_prog_loader;
  localparam int ID  = 44;
  localparam int DDA = 500;
  localparam int DDB = 8;
  localparam logic [31:0] HALT = 32'hffff_ffff;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start_s [2];
  logic ready_s [2];
  logic [31:0] img_inst [ID];
  logic [31:0] data_a [DDA];
  logic [31:0] data_b [DDB];

  logic        vld [2];
  logic        sel [2];
  logic [15:0] addr [2];
  logic [31:0] data [2];
  logic        bsy [2];
  logic        dn [2];
  logic        crst [2];
  logic [15:0] icnt [2];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct { int d; logic [48:0] w; int cyc; } beat_t;
  beat_t got [$];
  logic [48:0] exp_q [$];
  int exp_icnt;
  logic        stall_prev [2];
  logic [48:0] prev_w [2];

  prog_loader_if #(.ADDR_W(16)) if_a ();
  prog_loader_if #(.ADDR_W(16)) if_b ();
  assign if_a.wr_ready = ready_s[0];
  assign if_b.wr_ready = ready_s[1];

  prog_loader #(.INST_DEPTH(ID), .DATA_DEPTH(DDA), .ADDR_W(16), .LOAD_DATA(0)) u_a (
    .clk(clk), .rstn(rstn), .start(start_s[0]), .img_inst(img_inst), .img_data(data_a),
    .wr(if_a), .busy(bsy[0]), .done(dn[0]), .core_rstn(crst[0]), .inst_count(icnt[0]));

  prog_loader #(.INST_DEPTH(ID), .DATA_DEPTH(DDB), .ADDR_W(16), .LOAD_DATA(1)) u_b (
    .clk(clk), .rstn(rstn), .start(start_s[1]), .img_inst(img_inst), .img_data(data_b),
    .wr(if_b), .busy(bsy[1]), .done(dn[1]), .core_rstn(crst[1]), .inst_count(icnt[1]));

  assign vld[0] = if_a.wr_valid;  assign vld[1] = if_b.wr_valid;
  assign sel[0] = if_a.wr_sel;    assign sel[1] = if_b.wr_sel;
  assign addr[0] = if_a.wr_addr;  assign addr[1] = if_b.wr_addr;
  assign data[0] = if_a.wr_data;  assign data[1] = if_b.wr_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  // Record every handshake and check that stalled beats hold steady.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (stall_prev[d]) begin
        chk("hold_valid", 64'(vld[d]), 64'd1);
        chk("hold_word", 64'({sel[d], addr[d], data[d]}), 64'(prev_w[d]));
      end
      stall_prev[d] <= rstn && vld[d] && !ready_s[d];
      prev_w[d] <= {sel[d], addr[d], data[d]};
      if (rstn && vld[d] && ready_s[d]) got.push_back('{d, {sel[d], addr[d], data[d]}, cyc});
    end
  end

  // Reference: the instruction list up to and including the first halt (or the
  // whole image), followed by the full data image when the data phase is on.
  task automatic build(input int d);
    exp_q.delete();
    for (int i = 0; i < ID; i++) begin
      exp_q.push_back({1'b0, 16'(i), img_inst[i]});
      if (img_inst[i] == HALT) break;
    end
    exp_icnt = exp_q.size();
    if (d == 1) for (int j = 0; j < DDB; j++) exp_q.push_back({1'b1, 16'(j), data_b[j]});
  endtask

  task automatic chk_rst(input int d);
    chk("rst_valid", 64'(vld[d]), 0);
    chk("rst_sel", 64'(sel[d]), 0);
    chk("rst_addr", 64'(addr[d]), 0);
    chk("rst_data", 64'(data[d]), 0);
    chk("rst_busy", 64'(bsy[d]), 0);
    chk("rst_done", 64'(dn[d]), 0);
    chk("rst_crst", 64'(crst[d]), 0);
    chk("rst_icnt", 64'(icnt[d]), 0);
  endtask

  task automatic run_load(input int d, input bit rnd, input int start_at, input int rst_at);
    int c;
    int crst_bad;
    bit hit_s;
    c = 0; crst_bad = 0; hit_s = 1'b0;
    build(d);
    got.delete();
    start_s[d] = 1'b1;
    ready_s[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start_s[d] = 1'b0;
    chk("st_busy", 64'(bsy[d]), 1);
    chk("st_done", 64'(dn[d]), 0);
    chk("st_crst", 64'(crst[d]), 0);
    chk("st_icnt", 64'(icnt[d]), 0);
    chk("st_beat", 64'({vld[d], sel[d], addr[d], data[d]}), 64'({1'b1, exp_q[0]}));
    while (!dn[d] && c < 4000) begin
      if (crst[d]) crst_bad++;
      if (start_at >= 0 && got.size() == start_at && !hit_s) begin
        start_s[d] = 1'b1;
        hit_s = 1'b1;
      end else begin
        start_s[d] = 1'b0;
      end
      if (rst_at >= 0 && got.size() == rst_at) begin
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        start_s[d] = 1'b0;
        chk_rst(d);
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_nowrite", 64'(got.size()), 64'(rst_at));
        chk("rst_idle", 64'(vld[d]), 0);
        return;
      end
      ready_s[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    start_s[d] = 1'b0;
    chk("load_end", 64'(dn[d]), 1);
    chk("n_beats", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk("beat_dut", 64'(got[i].d), 64'(d));
      chk("beat", 64'(got[i].w), 64'(exp_q[i]));
    end
    chk("icnt", 64'(icnt[d]), 64'(exp_icnt));
    chk("crst_low_load", 64'(crst_bad), 0);
    chk("busy_end", 64'(bsy[d]), 0);
    chk("crst_end", 64'(crst[d]), 1);
    chk("valid_end", 64'(vld[d]), 0);
    if (got.size() > 0) begin
      chk("crst_lat", 64'(cyc - got[got.size()-1].cyc), 1);
      if (!rnd) chk("no_bubble", 64'(got[got.size()-1].cyc - got[0].cyc + 1), 64'(got.size()));
    end
  endtask

  task automatic fill_inst(input int halt_pos);
    for (int i = 0; i < ID; i++) begin
      img_inst[i] = $urandom();
      if (img_inst[i] == HALT) img_inst[i] = 32'h0;
    end
    img_inst[0] = 32'h2001_0014;
    if (halt_pos < ID) img_inst[halt_pos] = HALT;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; ready_s[d] = 1'b0; stall_prev[d] = 1'b0; prev_w[d] = '0;
    end
    for (int j = 0; j < DDA; j++) data_a[j] = $urandom();
    for (int j = 0; j < DDB; j++) data_b[j] = $urandom();
    fill_inst(ID - 1);
    rstn = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk_rst(0);
    chk_rst(1);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Full 44-word image, always ready, no data phase.
    run_load(0, 1'b0, -1, -1);
    // Restart from DONE, random back-pressure.
    run_load(0, 1'b1, -1, -1);
    // Reset at beat 20, then reload from address 0.
    run_load(0, 1'b0, -1, 20);
    run_load(0, 1'b0, -1, -1);
    // Start pulse while busy at beat 10 is ignored.
    run_load(0, 1'b1, 10, -1);
    run_load(0, 1'b0, 10, -1);

    // Halt at index 5 with data phase.
    fill_inst(5);
    run_load(1, 1'b0, -1, -1);
    run_load(1, 1'b1, 10, -1);

    // Random halt positions (ID means no halt word at all).
    for (int k = 0; k < 6; k++) begin
      fill_inst(int'($urandom_range(0, ID)));
      for (int j = 0; j < DDB; j++) data_b[j] = $urandom();
      run_load(1, k[0], -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
